cmos_pattern_timing_gen: RTL and testbench
==========================================

// Module: cmos_pattern_timing_gen
// PURPOSE
//  Synthesizable, parametrised CMOS-camera timing generator with a built-in test-pattern source.
//  Drives vsync/href/clken/data in the same format as the sensor front end.
//  Feeds the VIP pipeline (e.g. rgb2ycbcr) on-chip or in simulation, with no BMP file needed.
//  Adds run/stop control, pattern modes, frame counting and frame-aligned mode changes.
// PARAMETERS
//  DW        8    bits per colour channel
//  CH        3    channels per pixel (1 or 3); data = {C2,C1,C0} = {R,G,B}
//  H_DISP    640  active pixels per line (>=8, multiple of 8)
//  V_DISP    480  active lines per frame
//  H_SYNC    5    line sync cycles;   H_BACK 5 back porch;   H_FRONT 5 front porch
//  V_SYNC    1    frame sync lines;   V_BACK 0 back porch;   V_FRONT 1 front porch
//  CHK_LOG2  4    checkerboard square size = 2**CHK_LOG2 pixels
//  VS_POL    1    1: vsync high outside sync lines; 0: inverted
// PORTS
//  clk          in   1      pixel clock
//  rst_n        in   1      asynchronous reset, active-low
//  en           in   1      run request (level)
//  mode         in   2      0 colour bar, 1 gradient, 2 checkerboard, 3 solid
//  solid_color  in   CH*DW  pixel value for mode 3
//  vsync        out  1      frame sync
//  href         out  1      line-valid, high on active pixels
//  clken        out  1      pixel enable (== href)
//  data         out  CH*DW  pixel data, 0 when href=0
//  x_pos,y_pos  out  11     active coordinates of the current pixel, 0 when href=0
//  frame_cnt    out  16     completed-frame count, wraps 0xFFFF->0
//  frame_done   out  1      1-cycle pulse on the last cycle of each frame
//  busy         out  1      FSM != IDLE
// BEHAVIOUR
//  - Reset: every output 0 (vsync = ~VS_POL), hcnt=vcnt=0, FSM=IDLE, latched mode=0.
//  - H_TOTAL=H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL=V_SYNC+V_BACK+V_DISP+V_FRONT.
//  - Counters: hcnt 0..H_TOTAL-1, wraps to 0. vcnt advances when hcnt wraps and wraps at V_TOTAL-1.
//    Counters advance only in RUN/STOP_PEND; they hold at 0 in IDLE.
//  - FSM IDLE: en=1 -> RUN, with counting starting next cycle at (0,0).
//  - FSM RUN: en=0 -> STOP_PEND; the current frame always completes.
//  - FSM STOP_PEND: en=1 -> RUN (no gap). At frame end with en=0 -> IDLE, counters cleared.
//    Frame end = hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1.
//  - active = vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP) && hcnt in [H_SYNC+H_BACK, +H_DISP).
//    x = hcnt-(H_SYNC+H_BACK); y = vcnt-(V_SYNC+V_BACK).
//  - All outputs are registered with 1-cycle latency from the counter state.
//  - vsync = (vcnt>=V_SYNC) XNOR VS_POL; it is driven ~VS_POL in IDLE.
//  - mode and solid_color are latched only at (hcnt,vcnt)=(0,0) in RUN and when leaving IDLE.
//    Mid-frame changes take effect next frame, so there is no tearing.
//  - Colour bar: bar b = x / (H_DISP/8), b=0..7.
//    Bars = white, yellow, cyan, green, magenta, red, blue, black.
//    Each channel is all-ones or 0 (R=~b[1], G=~b[2], B=~b[0]).
//    CH=1 outputs the G channel.
//  - Gradient: every channel = x[DW-1:0] (wraps modulo 2**DW).
//    For DW>11, x is zero-extended.
//  - Checkerboard: all-ones if x[CHK_LOG2]^y[CHK_LOG2], else 0.
//  - frame_done and the frame_cnt increment happen on the same cycle.
//    This occurs at frame end, including the final frame before IDLE.
//  - Reset mid-frame aborts immediately to the reset state; no partial-frame pulse.
// CONFIGURATION
//  - CPTG_SCROLL_EN defined: pattern x becomes xs = x + frame_cnt[7:0].
//    When xs>=H_DISP, xs = xs-H_DISP, so the pattern scrolls 1 px per frame. Requires H_DISP>=256.
//    x_pos still reports the unscrolled x.
//  - CPTG_SCROLL_EN undefined: xs = x, with no adder or compare logic synthesized.
// TESTING  (H_DISP=16,V_DISP=4,H_SYNC=2,H_BACK=2,H_FRONT=2,V_SYNC=1,V_BACK=0,V_FRONT=1;
//           H_TOTAL=22,V_TOTAL=6, 132 cycles/frame)
//  1. en=1 held, mode=0 -> each line has 16 href cycles in 4 lines per frame.
//     data sequence per line: FFFFFF x2, FFFF00 x2, ..., 000000 x2.
//     frame_done every 132 cycles; frame_cnt 0->1->2.
//  2. mode=1 -> data per line = 000000,010101,...,0F0F0F.
//     Drop en mid-frame -> frame finishes, busy falls after frame_done, vsync=~VS_POL.
//  3. mode=2 with CHK_LOG2=1 -> line0 data 000000 x2, FFFFFF x2 repeating; line2 inverted.
//  4. Switch mode 0->3 mid-frame (solid_color=123456) -> current frame stays bars;
//     next frame is all 123456.
//  5. rst_n low at hcnt=10,vcnt=2 -> outputs 0 asynchronously, frame_cnt=0, no frame_done.
//     After release with en=1, restart at (0,0).
//  6. Re-assert en during STOP_PEND -> no idle cycle, frames continue back-to-back.
//     frame_cnt wraps 0xFFFF->0 (preload via force).

Source files
------------

// File: rtl/cmos_pattern_timing_gen_if.sv
// cmos_pattern_timing_gen_if
//   Bundles the control inputs and the sensor-style video outputs of
//   cmos_pattern_timing_gen.
//   master : the timing generator. It takes en/mode/solid_color and drives the video signals.
//   slave  : the consumer (VIP pipeline or testbench).
// Signals
//   en           run request (level)
//   mode         0 colour bar, 1 gradient, 2 checkerboard, 3 solid
//   solid_color  pixel value for mode 3
//   vsync        frame sync
//   href         line valid
//   clken        pixel enable (same as href)
//   data         pixel data {C2,C1,C0}
//   x_pos/y_pos  active coordinates of the current pixel
//   frame_cnt    completed-frame count
//   frame_done   frame-end pulse
//   busy         generator not idle
interface cmos_pattern_timing_gen_if #(
    parameter int DW = 8,
    parameter int CH = 3
);
    logic                 en;
    logic [1:0]           mode;
    logic [CH*DW-1:0]     solid_color;
    logic                 vsync;
    logic                 href;
    logic                 clken;
    logic [CH*DW-1:0]     data;
    logic [10:0]          x_pos;
    logic [10:0]          y_pos;
    logic [15:0]          frame_cnt;
    logic                 frame_done;
    logic                 busy;

    modport master (
        input  en, mode, solid_color,
        output vsync, href, clken, data, x_pos, y_pos, frame_cnt, frame_done, busy
    );

    modport slave (
        output en, mode, solid_color,
        input  vsync, href, clken, data, x_pos, y_pos, frame_cnt, frame_done, busy
    );
endinterface

// File: rtl/cmos_pattern_timing_gen.sv
// cmos_pattern_timing_gen
//   CMOS-camera timing generator with a built-in test-pattern source.
//   It produces vsync/href/clken/data in sensor front-end format, so the VIP
//   pipeline can be fed without image files.
//   Ports
//     clk    pixel clock
//     rst_n  asynchronous active-low reset
//     bus    cmos_pattern_timing_gen_if.master
//            inputs : en, mode, solid_color
//            outputs: vsync, href, clken, data, x_pos, y_pos, frame_cnt,
//                     frame_done, busy
//   Build option
//     CPTG_SCROLL_EN  When defined, the pattern x coordinate is offset by
//                     frame_cnt[7:0] modulo H_DISP, so the pattern scrolls
//                     by 1 px per frame. This needs H_DISP >= 256.
//                     x_pos still reports the unscrolled x.
module cmos_pattern_timing_gen #(
    parameter int DW       = 8,
    parameter int CH       = 3,
    parameter int H_DISP   = 640,
    parameter int V_DISP   = 480,
    parameter int H_SYNC   = 5,
    parameter int H_BACK   = 5,
    parameter int H_FRONT  = 5,
    parameter int V_SYNC   = 1,
    parameter int V_BACK   = 0,
    parameter int V_FRONT  = 1,
    parameter int CHK_LOG2 = 4,
    parameter int VS_POL   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cmos_pattern_timing_gen_if.master     bus
);

    localparam int CW      = 16;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT0   = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_ACT1   = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_ACT0   = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_ACT1   = CW'(V_SYNC + V_BACK + V_DISP);
    localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
    localparam logic [10:0]   BAR_W    = 11'(H_DISP / 8);
    localparam logic          VS_ON    = (VS_POL != 0);

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

    state_t              state;
    logic [CW-1:0]       hcnt;
    logic [CW-1:0]       vcnt;
    logic [1:0]          mode_q;
    logic [CH*DW-1:0]    solid_q;

    logic                vsync_q;
    logic                href_q;
    logic [CH*DW-1:0]    data_q;
    logic [10:0]         x_q;
    logic [10:0]         y_q;
    logic [15:0]         frame_cnt_q;
    logic                frame_done_q;
    logic                busy_q;

    logic                running;
    logic                frame_end;
    logic                active;
    logic                latch_cfg;
    logic [10:0]         x;
    logic [10:0]         y;
    logic [10:0]         xs;
    logic [2:0]          bar;
    logic                chk;
    logic                ch_on;
    logic [DW-1:0]       grad;
    logic [CH*DW-1:0]    pix;

    assign running   = (state != IDLE);
    assign frame_end = running && (hcnt == H_LAST) && (vcnt == V_LAST);
    assign active    = running && (vcnt >= V_ACT0) && (vcnt < V_ACT1)
                                && (hcnt >= H_ACT0) && (hcnt < H_ACT1);
    // The frame's pattern settings are captured at its first counter position.
    // This keeps a mid-frame change from tearing the image.
    assign latch_cfg = ((state == IDLE) && bus.en) ||
                       ((state == RUN) && (hcnt == '0) && (vcnt == '0));

    assign x = 11'(hcnt - H_ACT0);
    assign y = 11'(vcnt - V_ACT0);

`ifdef CPTG_SCROLL_EN
    logic [10:0] xsum;
    assign xsum = x + {3'b000, frame_cnt_q[7:0]};
    assign xs   = (xsum >= 11'(H_DISP)) ? (xsum - 11'(H_DISP)) : xsum;
`else
    assign xs = x;
`endif

    assign bar  = 3'(xs / BAR_W);
    assign chk  = xs[CHK_LOG2] ^ y[CHK_LOG2];
    assign grad = DW'(32'(xs));

    always_comb begin
        pix   = '0;
        ch_on = 1'b0;
        case (mode_q)
            2'd0: begin
                // Bar b: R=~b[1], G=~b[2], B=~b[0]. A mono build shows G.
                for (int unsigned c = 0; c < CH; c++) begin
                    if (CH == 1)     ch_on = ~bar[2];
                    else if (c == 2) ch_on = ~bar[1];
                    else if (c == 1) ch_on = ~bar[2];
                    else             ch_on = ~bar[0];
                    pix[c*DW +: DW] = {DW{ch_on}};
                end
            end
            2'd1: begin
                for (int unsigned c = 0; c < CH; c++) begin
                    pix[c*DW +: DW] = grad;
                end
            end
            2'd2:    pix = {(CH*DW){chk}};
            default: pix = solid_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hcnt         <= '0;
            vcnt         <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            vsync_q      <= ~VS_ON;
            href_q       <= 1'b0;
            data_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            href_q       <= active;
            data_q       <= active ? pix : '0;
            x_q          <= active ? x : '0;
            y_q          <= active ? y : '0;
            vsync_q      <= running ? ((vcnt >= V_SYNC_C) ~^ VS_ON) : ~VS_ON;
            frame_done_q <= frame_end;
            frame_cnt_q  <= frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
            busy_q       <= running;

            if (latch_cfg) begin
                mode_q  <= bus.mode;
                solid_q <= bus.solid_color;
            end

            case (state)
                IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (bus.en) state <= RUN;
                end
                RUN, STOP_PEND: begin
                    if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                    if (state == RUN) begin
                        if (!bus.en) state <= STOP_PEND;
                    end else if (bus.en) begin
                        state <= RUN;
                    end else if (frame_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.clken      = href_q;
    assign bus.data       = data_q;
    assign bus.x_pos      = x_q;
    assign bus.y_pos      = y_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cmos_pattern_timing_gen.sv
// tb_cmos_pattern_timing_gen
//   Directed test of cmos_pattern_timing_gen. The DUT is built with a small
//   raster: H_TOTAL=22, V_TOTAL=6, 132 cycles per frame.
//   Window k is the negedge sample that shows the outputs for counter position k
//   of the current run.
module tb_cmos_pattern_timing_gen;

    localparam int FRAME = 132;

    logic clk = 1'b0;
    logic rst_n;

    cmos_pattern_timing_gen_if #(.DW(8), .CH(3)) bus ();

    cmos_pattern_timing_gen #(
        .DW(8), .CH(3), .H_DISP(16), .V_DISP(4),
        .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(0), .V_FRONT(1),
        .CHK_LOG2(1), .VS_POL(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    int          n_assert = 0;
    int          n_fail   = 0;
    int          k        = 0;
    logic [15:0] exp_fc   = '0;
    logic [1:0]  exp_mode = '0;
    logic [23:0] exp_solid = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s (k=%0d): observed %h expected %h", tag, k, obs, exp_v);
        end
    endtask

    function automatic logic [23:0] exp_pix(input logic [1:0] m, input int xx, input int yy,
                                            input logic [23:0] s);
        case (m)
            2'd0:    return BARS[xx / 2];
            2'd1:    return {3{8'(xx)}};
            2'd2:    return ((((xx >> 1) ^ (yy >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    task automatic check_win();
        int kf, h, v, xx, yy;
        bit act;
        logic [23:0] ep;
        kf  = k % FRAME;
        h   = kf % 22;
        v   = kf / 22;
        act = (v >= 1) && (v < 5) && (h >= 4) && (h < 20);
        xx  = act ? h - 4 : 0;
        yy  = act ? v - 1 : 0;
        ep  = act ? exp_pix(exp_mode, xx, yy, exp_solid) : 24'h0;
        if (kf == FRAME - 1) exp_fc = exp_fc + 16'd1;
        chk("href",       32'(bus.href),       32'(act));
        chk("clken",      32'(bus.clken),      32'(act));
        chk("data",       32'(bus.data),       32'(ep));
        chk("x_pos",      32'(bus.x_pos),      32'(xx));
        chk("y_pos",      32'(bus.y_pos),      32'(yy));
        chk("vsync",      32'(bus.vsync),      32'(v >= 1));
        chk("frame_done", 32'(bus.frame_done), 32'(kf == FRAME - 1));
        chk("frame_cnt",  32'(bus.frame_cnt),  32'(exp_fc));
        chk("busy",       32'(bus.busy),       32'd1);
        k++;
    endtask

    task automatic run_to(input int kend);
        while (k < kend) begin
            @(negedge clk);
            check_win();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_href"},       32'(bus.href),       32'd0);
        chk({tag, "_clken"},      32'(bus.clken),      32'd0);
        chk({tag, "_data"},       32'(bus.data),       32'd0);
        chk({tag, "_x_pos"},      32'(bus.x_pos),      32'd0);
        chk({tag, "_y_pos"},      32'(bus.y_pos),      32'd0);
        chk({tag, "_vsync"},      32'(bus.vsync),      32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_frame_cnt"},  32'(bus.frame_cnt),  32'(exp_fc));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.en          = 1'b0;
        bus.mode        = 2'd0;
        bus.solid_color = 24'h0;

        // Reset values.
        #3;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle0");

        // Colour bars. A mid-frame switch to solid waits for the next frame.
        bus.en   = 1'b1;
        bus.mode = 2'd0;
        @(negedge clk);
        check_idle("start_a");
        k = 0;
        run_to(301);
        bus.mode        = 2'd3;
        bus.solid_color = 24'h123456;
        run_to(3 * FRAME);
        exp_mode  = 2'd3;
        exp_solid = 24'h123456;
        run_to(401);
        bus.mode = 2'd1;
        run_to(4 * FRAME);
        exp_mode = 2'd1;
        // Dropping en mid-frame still lets the frame finish.
        run_to(561);
        bus.en = 1'b0;
        run_to(5 * FRAME);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("stopped");
        end

        // Checkerboard, plus STOP_PEND re-entered mid-frame and at frame end.
        bus.mode = 2'd2;
        bus.en   = 1'b1;
        @(negedge clk);
        check_idle("start_b");
        k = 0;
        exp_mode = 2'd2;
        run_to(51);
        bus.en = 1'b0;
        run_to(101);
        bus.en = 1'b1;
        run_to(201);
        bus.en = 1'b0;
        run_to(263);
        bus.en = 1'b1;
        run_to(301);
        // Preload the frame counter so it wraps at the next frame end.
        force dut.frame_cnt_q = 16'hFFFF;
        exp_fc = 16'hFFFF;
        run_to(302);
        release dut.frame_cnt_q;
        run_to(450);

        // Reset while the counters are at (10,2).
        rst_n = 1'b0;
        exp_fc = '0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        check_idle("in_rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("restart");
        k = 0;
        run_to(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
